seven_segment_sink: RTL and testbench

//  Consumer end of the seven-segment stb/ack streams (annode, cathode) produced by the

---
 rtl/seven_segment_pkg.sv | 13 +
 rtl/stream_sink_reg.sv | 30 +++
 rtl/seven_segment_sink.sv | 145 ++++++++++++++
 tb/tb_seven_segment_sink.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/seven_segment_pkg.sv
// Shared types and constants for the seven-segment pin driver.
package seven_segment_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned DATA_W = 8;
    localparam logic [DATA_W-1:0] ALL_OFF = 8'hFF;

    typedef enum logic {
        DRIVE = 1'b0,
        BLANK = 1'b1
    } state_t;

endpackage

// File: rtl/stream_sink_reg.sv
// One stb/ack consumer channel: registered one-cycle ack pulse, transfer strobe and data slice.
module stream_sink_reg
    import seven_segment_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] data,
    input  logic              stb,
    input  logic              can_accept,
    output logic              ack,
    output logic              xfer_c,
    output logic [DATA_W-1:0] word_c
);

    logic unused_upper_c;

    // Ack only when idle, so a held stb yields at most one transfer every two cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            ack <= 1'b0;
        end else begin
            ack <= stb & ~ack & can_accept;
        end
    end

    assign xfer_c         = stb & ack;
    assign word_c         = data[DATA_W-1:0];
    assign unused_upper_c = ^data[WORD_W-1:DATA_W];

endmodule

// File: rtl/seven_segment_sink.sv
// Drives Nexys 4 AN/CA pins from two stb/ack streams with anti-ghosting blank gaps
// on anode changes and a watchdog that blanks a stalled display.
module seven_segment_sink
    import seven_segment_pkg::*;
#(
    parameter int unsigned BLANK_CYCLES    = 16,
    parameter int unsigned WATCHDOG_CYCLES = 100000,
    parameter bit          INVERT          = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] input_annode,
    input  logic              input_annode_stb,
    output logic              input_annode_ack,
    input  logic [WORD_W-1:0] input_cathode,
    input  logic              input_cathode_stb,
    output logic              input_cathode_ack,
    output logic [DATA_W-1:0] annode,
    output logic [DATA_W-1:0] cathode
);

    localparam int unsigned BLANK_W = $clog2(BLANK_CYCLES + 1);
    localparam int unsigned WD_W    = (WATCHDOG_CYCLES > 0) ? $clog2(WATCHDOG_CYCLES + 1) : 1;
    localparam logic [BLANK_W-1:0] BLANK_LOAD = BLANK_W'(BLANK_CYCLES);
    localparam logic [WD_W-1:0]    WD_MAX     = WD_W'(WATCHDOG_CYCLES);
    localparam logic [DATA_W-1:0]  INV_MASK   = {DATA_W{INVERT}};

    state_t              state, state_d;
    logic [DATA_W-1:0]   cur_an, cur_an_d;
    logic [DATA_W-1:0]   pending_an, pending_an_d;
    logic [DATA_W-1:0]   shadow_ca, shadow_ca_d;
    logic [DATA_W-1:0]   an_q, an_d;
    logic [DATA_W-1:0]   ca_q, ca_d;
    logic [BLANK_W-1:0]  blank_cnt, blank_cnt_d;
    logic [WD_W-1:0]     wd_cnt, wd_cnt_d;

    logic                an_can_accept_c;
    logic                an_xfer_c, ca_xfer_c;
    logic [DATA_W-1:0]   an_word_c, ca_word_c;

    assign an_can_accept_c = (state == DRIVE);

    stream_sink_reg u_annode_sink (
        .clk        (clk),
        .rst        (rst),
        .data       (input_annode),
        .stb        (input_annode_stb),
        .can_accept (an_can_accept_c),
        .ack        (input_annode_ack),
        .xfer_c     (an_xfer_c),
        .word_c     (an_word_c)
    );

    stream_sink_reg u_cathode_sink (
        .clk        (clk),
        .rst        (rst),
        .data       (input_cathode),
        .stb        (input_cathode_stb),
        .can_accept (1'b1),
        .ack        (input_cathode_ack),
        .xfer_c     (ca_xfer_c),
        .word_c     (ca_word_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= DRIVE;
            cur_an     <= ALL_OFF;
            pending_an <= ALL_OFF;
            shadow_ca  <= ALL_OFF;
            an_q       <= ALL_OFF;
            ca_q       <= ALL_OFF;
            blank_cnt  <= '0;
            wd_cnt     <= '0;
        end else begin
            state      <= state_d;
            cur_an     <= cur_an_d;
            pending_an <= pending_an_d;
            shadow_ca  <= shadow_ca_d;
            an_q       <= an_d;
            ca_q       <= ca_d;
            blank_cnt  <= blank_cnt_d;
            wd_cnt     <= wd_cnt_d;
        end
    end

    always_comb begin
        state_d      = state;
        cur_an_d     = cur_an;
        pending_an_d = pending_an;
        shadow_ca_d  = shadow_ca;
        an_d         = an_q;
        ca_d         = ca_q;
        blank_cnt_d  = blank_cnt;
        wd_cnt_d     = wd_cnt;

        case (state)
            DRIVE: begin
                // A cathode arriving with an anode change belongs to the new digit.
                if (an_xfer_c && (an_word_c != cur_an)) begin
                    pending_an_d = an_word_c;
                    an_d         = ALL_OFF;
                    blank_cnt_d  = BLANK_LOAD;
                    state_d      = BLANK;
                    if (ca_xfer_c) begin
                        shadow_ca_d = ca_word_c;
                    end
                end else if (ca_xfer_c) begin
                    ca_d        = ca_word_c;
                    shadow_ca_d = ca_word_c;
                end
            end
            BLANK: begin
                if (ca_xfer_c) begin
                    shadow_ca_d = ca_word_c;
                end
                if (blank_cnt == BLANK_W'(1)) begin
                    state_d     = DRIVE;
                    an_d        = pending_an;
                    cur_an_d    = pending_an;
                    ca_d        = ca_xfer_c ? ca_word_c : shadow_ca;
                    blank_cnt_d = '0;
                end else begin
                    blank_cnt_d = blank_cnt - BLANK_W'(1);
                end
            end
            default: state_d = DRIVE;
        endcase

        // Watchdog saturates at WD_MAX; with WD_MAX == 0 it never advances.
        if (an_xfer_c) begin
            wd_cnt_d = '0;
        end else if (wd_cnt != WD_MAX) begin
            wd_cnt_d = wd_cnt + WD_W'(1);
            if (wd_cnt_d == WD_MAX) begin
                an_d     = ALL_OFF;
                cur_an_d = ALL_OFF;
            end
        end
    end

    assign annode  = an_q ^ INV_MASK;
    assign cathode = ca_q ^ INV_MASK;

endmodule

// File: tb/tb_seven_segment_sink.sv
// Scoreboard bench: directed stimulus pushes cycle-stamped expectations, a negedge monitor checks them.
module tb_seven_segment_sink;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] input_annode = '0;
    logic        input_annode_stb = 1'b0;
    logic        input_annode_ack;
    logic [31:0] input_cathode = '0;
    logic        input_cathode_stb = 1'b0;
    logic        input_cathode_ack;
    logic [7:0]  annode;
    logic [7:0]  cathode;

    seven_segment_sink #(
        .BLANK_CYCLES    (4),
        .WATCHDOG_CYCLES (50),
        .INVERT          (1'b0)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .input_annode      (input_annode),
        .input_annode_stb  (input_annode_stb),
        .input_annode_ack  (input_annode_ack),
        .input_cathode     (input_cathode),
        .input_cathode_stb (input_cathode_stb),
        .input_cathode_ack (input_cathode_ack),
        .annode            (annode),
        .cathode           (cathode)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        int         kind;
        logic [7:0] val;
    } exp_t;

    exp_t       sb[$];
    int         cyc = 0;
    int         total = 0;
    int         bad = 0;
    logic [7:0] act;

    localparam int K_AN = 0, K_CA = 1, K_AN_ACK = 2, K_CA_ACK = 3;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kind_name(input int k);
        case (k)
            K_AN:     return "annode";
            K_CA:     return "cathode";
            K_AN_ACK: return "annode_ack";
            default:  return "cathode_ack";
        endcase
    endfunction

    // Monitor: compare every expectation stamped with the current cycle; late ones are errors.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc <= cyc) begin
                case (sb[i].kind)
                    K_AN:     act = annode;
                    K_CA:     act = cathode;
                    K_AN_ACK: act = {7'b0, input_annode_ack};
                    default:  act = {7'b0, input_cathode_ack};
                endcase
                total++;
                if (sb[i].cyc != cyc || act !== sb[i].val) begin
                    bad++;
                    $display("FAIL %s at cycle %0d (checked %0d): got %h want %h",
                             kind_name(sb[i].kind), sb[i].cyc, cyc, act, sb[i].val);
                end
                sb.delete(i);
            end
        end
    end

    task automatic exp_pins(input int c0, input int c1, input logic [7:0] an, input logic [7:0] ca);
        for (int c = c0; c <= c1; c++) begin
            sb.push_back('{c, K_AN, an});
            sb.push_back('{c, K_CA, ca});
        end
    endtask

    task automatic exp_ack(input int c, input int kind, input logic v);
        sb.push_back('{c, kind, {7'b0, v}});
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Hold stb until ack is seen, then drop it right after the transfer edge.
    task automatic send(input logic do_an, input logic [7:0] an_v,
                        input logic do_ca, input logic [7:0] ca_v);
        logic an_pend, ca_pend, an_seen, ca_seen;
        int   n;
        an_pend = do_an;
        ca_pend = do_ca;
        an_seen = 1'b0;
        ca_seen = 1'b0;
        n = 0;
        if (do_an) begin
            input_annode     = {24'h5A5A5A, an_v};
            input_annode_stb = 1'b1;
        end
        if (do_ca) begin
            input_cathode     = {24'hA5A5A5, ca_v};
            input_cathode_stb = 1'b1;
        end
        while ((an_pend || ca_pend) && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (an_seen) begin
                input_annode_stb = 1'b0;
                an_pend = 1'b0;
                an_seen = 1'b0;
            end else if (an_pend && input_annode_ack) begin
                an_seen = 1'b1;
            end
            if (ca_seen) begin
                input_cathode_stb = 1'b0;
                ca_pend = 1'b0;
                ca_seen = 1'b0;
            end else if (ca_pend && input_cathode_ack) begin
                ca_seen = 1'b1;
            end
        end
        if (an_pend || ca_pend) begin
            total++;
            bad++;
            $display("FAIL handshake_timeout at cycle %0d: pending an=%0b ca=%0b want none",
                     cyc, an_pend, ca_pend);
            input_annode_stb  = 1'b0;
            input_cathode_stb = 1'b0;
        end
    endtask

    initial begin
        // Reset held for edges 1..3, then idle.
        exp_pins(1, 6, 8'hFF, 8'hFF);
        for (int c = 1; c <= 3; c++) begin
            exp_ack(c, K_AN_ACK, 1'b0);
            exp_ack(c, K_CA_ACK, 1'b0);
        end
        wait_to(3);
        rst = 1'b0;

        // Cathode C0 in DRIVE.
        wait_to(6);
        exp_ack(6, K_CA_ACK, 1'b0);
        exp_ack(7, K_CA_ACK, 1'b1);
        exp_ack(8, K_CA_ACK, 1'b0);
        exp_pins(7, 7, 8'hFF, 8'hFF);
        exp_pins(8, 9, 8'hFF, 8'hC0);
        send(1'b0, 8'h00, 1'b1, 8'hC0);

        // Anode FE: 4 blank cycles, then FE.
        wait_to(10);
        exp_ack(11, K_AN_ACK, 1'b1);
        exp_ack(12, K_AN_ACK, 1'b0);
        exp_pins(10, 15, 8'hFF, 8'hC0);
        exp_pins(16, 17, 8'hFE, 8'hC0);
        send(1'b1, 8'hFE, 1'b0, 8'h00);

        // Anode FD raised during the gap is held off until DRIVE.
        wait_to(13);
        for (int c = 14; c <= 16; c++) exp_ack(c, K_AN_ACK, 1'b0);
        exp_ack(17, K_AN_ACK, 1'b1);
        exp_ack(18, K_AN_ACK, 1'b0);
        exp_pins(18, 21, 8'hFF, 8'hC0);
        exp_pins(22, 22, 8'hFD, 8'hC0);
        send(1'b1, 8'hFD, 1'b0, 8'h00);

        // Back to FE, then repeat FE: no gap.
        wait_to(23);
        exp_ack(24, K_AN_ACK, 1'b1);
        exp_pins(25, 28, 8'hFF, 8'hC0);
        exp_pins(29, 29, 8'hFE, 8'hC0);
        send(1'b1, 8'hFE, 1'b0, 8'h00);
        wait_to(30);
        exp_ack(31, K_AN_ACK, 1'b1);
        exp_ack(32, K_AN_ACK, 1'b0);
        exp_pins(30, 33, 8'hFE, 8'hC0);
        send(1'b1, 8'hFE, 1'b0, 8'h00);

        // Simultaneous FD + A4: new cathode only appears with the new anode.
        wait_to(34);
        exp_ack(35, K_AN_ACK, 1'b1);
        exp_ack(35, K_CA_ACK, 1'b1);
        exp_ack(36, K_AN_ACK, 1'b0);
        exp_ack(36, K_CA_ACK, 1'b0);
        exp_pins(34, 35, 8'hFE, 8'hC0);
        exp_pins(36, 39, 8'hFF, 8'hC0);
        exp_pins(40, 40, 8'hFD, 8'hA4);
        send(1'b1, 8'hFD, 1'b1, 8'hA4);

        // Watchdog: last anode transfer at edge 36, blank at edge 86.
        wait_to(41);
        exp_pins(41, 85, 8'hFD, 8'hA4);
        exp_pins(86, 88, 8'hFF, 8'hA4);

        // Reset in the middle of a gap discards the pending anode.
        wait_to(90);
        exp_ack(91, K_AN_ACK, 1'b1);
        exp_pins(92, 93, 8'hFF, 8'hA4);
        exp_pins(94, 101, 8'hFF, 8'hFF);
        send(1'b1, 8'hFE, 1'b0, 8'h00);
        wait_to(93);
        rst = 1'b1;
        wait_to(94);
        rst = 1'b0;

        // Post-reset DRIVE with cur_an = FF.
        wait_to(100);
        exp_ack(101, K_AN_ACK, 1'b1);
        exp_pins(102, 105, 8'hFF, 8'hFF);
        exp_pins(106, 106, 8'hFD, 8'hFF);
        send(1'b1, 8'hFD, 1'b0, 8'h00);

        wait_to(110);
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_drain: got %0d entries left want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
